// File: rtl/offnariscv_stage_buf.sv
// ---------------------------------------------------------------------------
// offnariscv_stage_buf
//
// Elastic FIFO slot placed between two pipeline stages. It carries the stage
// tdata struct as a flat DATA_WIDTH-bit vector. Handshakes use valid/ready in
// the style of AXI-Stream. A synchronous flush supports branch and trap
// redirects, and an occupancy count is exported.
//
// Parameters:
//   DATA_WIDTH  payload width (set to $bits of the stage tdata struct)
//   DEPTH       number of entries, a power of two in the range 2..16
//   CNT_WIDTH   occupancy width; derived from DEPTH and not overridable
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous flush; discards every entry and any push that cycle
//   s_tvalid  upstream payload valid
//   s_tready  buffer can accept (registered state only)
//   s_tdata   upstream payload
//   m_tvalid  head entry valid (registered state only)
//   m_tready  downstream accepts
//   m_tdata   head entry payload
//   count     current occupancy, 0..DEPTH
//
// Optional feature, enabled by defining OFFNARISCV_STAGE_BUF_STATS_EN:
//   stall_cycles  counts cycles where m_tvalid && !m_tready (saturating)
//   flush_drops   counts entries and incoming pushes discarded by flush
//                 (saturating)
// ---------------------------------------------------------------------------
module offnariscv_stage_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 2,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [CNT_WIDTH-1:0]  count
`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_drops
`endif
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    // Both ready and valid come from count_q alone. This keeps m_tready from
    // reaching s_tready combinationally, so a full buffer only frees its
    // slot in the cycle after a pop.
    assign s_tready = (count_q != FULL_CNT);
    assign m_tvalid = (count_q != '0);
    assign count    = count_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // The storage is never reset. Masking the head while the buffer is empty
    // keeps unwritten (X) entries from reaching the next stage.
    assign m_tdata = m_tvalid ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            // A pop in this cycle still completes downstream. The buffer
            // state is cleared regardless.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // A push in a flush cycle is wrong-path data, so it is not stored.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q] <= s_tdata;
        end
    end

`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] drops_q;
    logic [32:0] drops_sum;

    // The extra top bit catches overflow so the counter can saturate.
    assign drops_sum = {1'b0, drops_q} + 33'(count_q) + 33'(s_tvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            if (m_tvalid && !m_tready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush) begin
                drops_q <= drops_sum[32] ? 32'hFFFF_FFFF : drops_sum[31:0];
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_drops  = drops_q;
`endif

`ifndef SYNTHESIS
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("offnariscv_stage_buf: DEPTH must be a power of two >= 2");
    end

    // Upstream may drop wrong-path data when a flush arrives. Outside a
    // flush, a stalled offer must be held steady.
    a_hold_offer: assert property (
        @(posedge clk) disable iff (!rst_n)
        (s_tvalid && !s_tready && !flush) |=> (flush || (s_tvalid && $stable(s_tdata)))
    );

    a_count_range: assert property (
        @(posedge clk) disable iff (!rst_n) (count_q <= FULL_CNT)
    );
`endif

endmodule

// File: tb/tb_offnariscv_stage_buf.sv
// ---------------------------------------------------------------------------
// Testbench for offnariscv_stage_buf (DATA_WIDTH=8, DEPTH=4).
// The reference model is a plain queue. On each rising edge it applies the
// push, pop, flush and reset rules to the bench's own inputs. A compare
// process checks every DUT output against that queue on each falling edge.
// Directed scenarios add literal expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_offnariscv_stage_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [CW-1:0] count;
`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   flush_drops;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] mq[$];
    logic [31:0]   stall_m = 0;
    logic [31:0]   drops_m = 0;

    offnariscv_stage_buf #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata (s_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .count   (count)
`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_drops (flush_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model. It reads only bench-driven inputs and its own queue.
    initial begin
        int  n;
        bit  mpush, mpop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                stall_m = 0;
                drops_m = 0;
            end else begin
                n     = mq.size();
                mpush = s_tvalid && (n < DEPTH);
                mpop  = m_tready && (n > 0);
                if ((n > 0) && !m_tready && (stall_m != 32'hFFFF_FFFF)) stall_m = stall_m + 1;
                if (flush) begin
                    drops_m = drops_m + n + (s_tvalid ? 1 : 0);
                    mq.delete();
                end else begin
                    if (mpop) void'(mq.pop_front());
                    if (mpush) mq.push_back(s_tdata);
                end
            end
        end
    end

    // Compare process: checks every output on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_count", 32'(count), 32'(mq.size()));
            check("cmp_m_tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
            check("cmp_s_tready", 32'(s_tready), 32'(mq.size() != DEPTH));
            if (mq.size() != 0) check("cmp_m_tdata", 32'(m_tdata), 32'(mq[0]));
`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
            check("cmp_stall", stall_cycles, stall_m);
            check("cmp_drops", flush_drops, drops_m);
`endif
        end
    end

    initial begin
        int nexp;
        bit accepted;
        rst_n = 1'b0; flush = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        #1;
        check("reset_count", 32'(count), 0);
        check("reset_m_tvalid", 32'(m_tvalid), 0);
        check("reset_s_tready", 32'(s_tready), 1);
        step(); step();
        rst_n = 1'b1;
        step();

        // Scenario 1: a single push appears one cycle later, with no bypass.
        s_tvalid = 1'b1; s_tdata = 8'hA5; m_tready = 1'b0;
        #1 check("t1_no_bypass", 32'(m_tvalid), 0);
        step();
        s_tvalid = 1'b0;
        $display("t1: push A5 -> m_tvalid=%0d m_tdata=%0h count=%0d", m_tvalid, m_tdata, count);
        check("t1_m_tvalid", 32'(m_tvalid), 1);
        check("t1_m_tdata", 32'(m_tdata), 32'hA5);
        check("t1_count", 32'(count), 1);
        check("t1_s_tready", 32'(s_tready), 1);
        m_tready = 1'b1; step(); m_tready = 1'b0;
        check("t1_drained", 32'(count), 0);

        // Scenario 2: fill to full. The fifth value is held until there is room.
        for (int i = 1; i <= 4; i++) begin
            s_tvalid = 1'b1; s_tdata = DW'(i); step();
        end
        s_tdata = 8'h05; step(); step();
        $display("t2: full -> count=%0d s_tready=%0d", count, s_tready);
        check("t2_full_count", 32'(count), 4);
        check("t2_full_ready", 32'(s_tready), 0);
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            $display("t2: pop %0d -> m_tvalid=%0d m_tdata=%0h", k, m_tvalid, m_tdata);
            check("t2_no_gap", 32'(m_tvalid), 1);
            check("t2_order", 32'(m_tdata), 32'(k + 1));
            accepted = s_tvalid && s_tready;
            step();
            if (accepted) s_tvalid = 1'b0;
        end
        m_tready = 1'b0;
        check("t2_empty", 32'(count), 0);

        // Scenario 3: 20 cycles of simultaneous push and pop.
        m_tready = 1'b1; nexp = 0;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = DW'(i);
            if (i > 0) check("t3_count", 32'(count), 1);
            if (m_tvalid) begin
                check("t3_data", 32'(m_tdata), 32'(nexp));
                nexp++;
            end
            step();
        end
        s_tvalid = 1'b0;
        if (m_tvalid) begin
            check("t3_data", 32'(m_tdata), 32'(nexp));
            nexp++;
        end
        step();
        $display("t3: streamed %0d values, count=%0d", nexp, count);
        check("t3_total", 32'(nexp), 20);
        m_tready = 1'b0;

        // Scenario 4: flush with three entries and a simultaneous push of 0x77.
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = DW'(8'h10 + i); step();
        end
        flush = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h77;
        step();
        flush = 1'b0; s_tvalid = 1'b0;
        $display("t4: flush -> count=%0d m_tvalid=%0d", count, m_tvalid);
        check("t4_count", 32'(count), 0);
        check("t4_m_tvalid", 32'(m_tvalid), 0);
`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
        check("t4_flush_drops", flush_drops, 4);
`endif
        m_tready = 1'b1;
        repeat (3) begin
            step();
            check("t4_no_77", 32'(m_tvalid), 0);
        end
        m_tready = 1'b0;

        // Scenario 5: asynchronous reset in the middle of a cycle.
        s_tvalid = 1'b1; s_tdata = 8'h21; step();
        s_tdata = 8'h22; step();
        s_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("t5: async reset -> m_tvalid=%0d count=%0d", m_tvalid, count);
        check("t5_async_valid", 32'(m_tvalid), 0);
        check("t5_async_count", 32'(count), 0);
        check("t5_async_ready", 32'(s_tready), 1);
        step();
        rst_n = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'h09; step();
        s_tdata = 8'h0B; step();
        s_tvalid = 1'b0;
        check("t5_first", 32'(m_tdata), 32'h09);
        check("t5_count", 32'(count), 2);
        m_tready = 1'b1; step();
        check("t5_second", 32'(m_tdata), 32'h0B);
        step(); m_tready = 1'b0;

`ifdef OFFNARISCV_STAGE_BUF_STATS_EN
        // Scenario 6: ten stall cycles after a fresh reset.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'h3C; step();
        s_tvalid = 1'b0;
        repeat (10) step();
        $display("t6: stall_cycles=%0d", stall_cycles);
        check("t6_stall", stall_cycles, 10);
        check("t6_drops_reset", flush_drops, 0);
        m_tready = 1'b1; step(); m_tready = 1'b0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/offnariscv_stage_buf.md
Name: offnariscv_stage_buf

Overview:
- Parametrised AXI-Stream-style elastic buffer for inter-stage payloads: pcgif, ifid, idrf, rfex, exwb and wbrf tdata structs.
- Generalises the single-register pipeline slot to configurable width and depth, with synchronous flush for branch/trap redirect and an occupancy output.
- Instantiated between each pair of pipeline stages; the payload struct is passed through flat as DATA_WIDTH bits.

Parameters:
- DATA_WIDTH, 32: payload width in bits; set to $bits of the stage tdata struct.
- DEPTH, 2: number of entries; power of two, 2..16.
- CNT_WIDTH, $clog2(DEPTH)+1: occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all entries.
- s_tvalid  input  1  upstream payload valid.
- s_tready  output  1  buffer can accept.
- s_tdata  input  DATA_WIDTH  upstream payload.
- m_tvalid  output  1  head entry valid.
- m_tready  input  1  downstream accepts.
- m_tdata  output  DATA_WIDTH  head entry payload.
- count  output  CNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries; write pointer wptr and read pointer rptr of $clog2(DEPTH) bits wrap naturally modulo DEPTH; count is a separate register.
- Handshakes:
  - push = s_tvalid && s_tready.
  - pop = m_tvalid && m_tready.
  - tvalid must not depend combinationally on tready at either side.
- s_tready = (count != DEPTH). It depends only on registered state; there is no combinational path from m_tready to s_tready.
- m_tvalid = (count != 0).
- m_tdata = mem[rptr], a combinational read of flops. When count==0, m_tdata is don't-care and must not be X in simulation; the stale entry is acceptable.
- Latency: data accepted in cycle N appears on m_tvalid/m_tdata in cycle N+1. No same-cycle bypass when empty.
- Throughput: one push and one pop per cycle sustained for DEPTH>=2.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full (count==DEPTH):
  - s_tready=0, so no push.
  - A pop in the same cycle frees the slot only from the next cycle.
- Empty (count==0): m_tvalid=0, so no pop. A push that cycle makes m_tvalid=1 next cycle.
- Flush has the highest priority. In a cycle with flush=1:
  - count, wptr and rptr go to 0 next cycle.
  - Any simultaneous push is discarded.
  - Any simultaneous pop handshake still counts as completed for the downstream stage, but the buffer state is cleared regardless.
  - s_tready keeps its normal value during flush; upstream must itself drop wrong-path data.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Reset (rst_n low, asynchronous):
  - count=0, wptr=0, rptr=0, so m_tvalid=0 and s_tready=1 immediately.
  - Storage array is not reset.
  - Reset mid-stream discards all entries. The first cycle after deassertion behaves as empty.
- Assertions (simulation only):
  - s_tvalid must stay high and s_tdata stable while !s_tready.
  - count <= DEPTH.
  - DEPTH is a power of two and >= 2.

Optional Feature:
- Macro: OFFNARISCV_STAGE_BUF_STATS_EN.
- With the macro defined, two extra output ports are added:
  - stall_cycles [31:0]: increments every cycle where m_tvalid && !m_tready.
  - flush_drops [31:0]: adds, per flush cycle, count plus 1 if s_tvalid was high that cycle. Each push dropped by flush counts once.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0 on rst_n low; flush does not clear them.
- Without the macro: the ports and logic are absent, and functional behaviour is identical.

Test Plan:
- Reset, then push 0xA5 at cycle 1 with m_tready=0 -> at cycle 2, m_tvalid=1, m_tdata=0xA5, count=1, s_tready=1.
- DEPTH=4, m_tready=0, push 0x1,0x2,0x3,0x4 on consecutive cycles -> count=4, s_tready=0. Fifth value 0x5 is held by upstream and not accepted. Raise m_tready -> outputs 0x1,0x2,0x3,0x4,0x5 in order with no gaps.
- Continuous push and pop for 20 cycles with values 0..19, DEPTH=2 -> count stays at 1 after the first cycle, outputs are 0..19 one per cycle, and pointers wrap without loss.
- Fill with 3 entries (DEPTH=4), assert flush together with s_tvalid=1 and s_tdata=0x77 -> next cycle count=0, m_tvalid=0, and 0x77 never appears. With STATS_EN, flush_drops=4.
- Fill with 2 entries, drop rst_n asynchronously mid-cycle -> m_tvalid=0 and count=0 before the next clock edge. After release, first push 0x9 emerges first.
- STATS_EN: hold m_tvalid=1 with m_tready=0 for 10 cycles -> stall_cycles=10. A preset near saturation stays at 32'hFFFF_FFFF.
